vga_sync_decoder: RTL and testbench
===================================

// Module: vga_sync_decoder
// PURPOSE
//  Receive-side counterpart of vga_timing_gen: recovers pixel coordinates from raw hs/vs/active.
//  Measures line and frame timing, and declares lock once the input matches the expected mode.
//  Used for loopback self-check of the timing generator and for capture/overlay logic.
//  Outputs x/y are in the same format that VGA_Coord_Calc consumes.
// PARAMETERS
//  H_TOTAL      800  expected clocks per line (hs edge to hs edge)
//  V_TOTAL      525  expected lines per frame (hs edges between vs edges)
//  H_ACTIVE     640  expected active clocks per line
//  V_ACTIVE     480  expected active lines per frame
//  SYNC_POL     0    sync polarity; 0 = hs/vs active-low (640x480 standard)
//  LOCK_FRAMES  2    consecutive good frames required for lock
// PORTS
//  clk           in   1   pixel clock; single clock domain
//  rst           in   1   reset; synchronous, active-high
//  hs_in         in   1   horizontal sync, polarity per SYNC_POL
//  vs_in         in   1   vertical sync, polarity per SYNC_POL
//  active_in     in   1   display-enable, high in visible region
//  x             out  10  recovered column; 0 at first active pixel
//  y             out  10  recovered row; 0 at first active line of frame
//  pixel_valid   out  1   x/y refer to a visible pixel
//  line_start    out  1   1-cycle pulse on hs assertion edge
//  frame_start   out  1   1-cycle pulse on vs assertion edge
//  locked        out  1   timing matches parameters for LOCK_FRAMES frames
//  h_err         out  1   1-cycle pulse: measured line period != H_TOTAL
//  v_err         out  1   1-cycle pulse: measured line count != V_TOTAL, or active lines != V_ACTIVE
//  act_err       out  1   1-cycle pulse: active run length != H_ACTIVE
//  h_total_meas  out  11  last measured line period, saturating at 2047
//  v_total_meas  out  10  last measured lines per frame, saturating at 1023
// BEHAVIOUR
//  Reset:
//  - With rst high at clk edge, every output and internal counter -> 0 and state -> SEARCH.
//  - Reset mid-frame discards partial measurements.
//  Pipeline:
//  - Stage 1 registers inputs and normalises polarity to active-high.
//  - Stage 2 edge-detects them and drives all outputs.
//  - Latency is 2 clk from an input change to the corresponding output.
//  Counters:
//  - x clears on active rising edge and increments each active cycle, saturating at 1023.
//  - y clears on frame_start, increments on each active falling edge, saturating at 1023.
//  - pixel_valid is active delayed 2 cycles.
//  Measurement:
//  - hcnt counts clocks and restarts at 1 on each line_start.
//  - On line_start, the prior hcnt is latched to h_total_meas. In ACQUIRE/LOCKED, a mismatch
//    pulses h_err. The first line_start after SEARCH is not checked.
//  - vcnt counts line_starts. On frame_start it is latched to v_total_meas and compared
//    with V_TOTAL. The active-line count is compared with V_ACTIVE. Either mismatch pulses v_err.
//  - On each active falling edge, the run length is compared with H_ACTIVE; a mismatch pulses act_err.
//  Simultaneous edges:
//  - When hs and vs assert in the same cycle, the line is counted first, then the frame closes.
//  - Such a frame therefore includes that line in v_total_meas.
//  FSM:
//  - SEARCH: on frame_start -> ACQUIRE, good = 0.
//  - ACQUIRE: any err pulse -> good = 0 (stay).
//    frame_start with no error during the frame -> good++; at good == LOCK_FRAMES -> LOCKED.
//  - LOCKED: locked = 1. Any err pulse -> ACQUIRE, good = 0, locked = 0 on the following cycle.
//  - Error flags are never asserted in SEARCH.
// STRUCTURE
//  - Shared include vga_params.vh: 640x480 H/V totals, active sizes and sync polarity,
//    also used by vga_timing_gen.
//  - FSM state encodings localparam-ed here.
//  - Sub-module vga_edge_det: 2-flop register plus rise/fall pulse, instantiated 3x.
// TESTING
//  T1 rst=1 for 3 clk with random syncs -> all outputs 0; no err pulse in the first frame.
//  T2 loopback from vga_timing_gen (same rst sense inverted) -> locked rises at the 3rd frame_start
//     (about 840k clk); x/y/pixel_valid equal the generator x/y/active delayed 2 clk;
//     h_total_meas = 800, v_total_meas = 525.
//  T3 after lock, suppress one hs pulse -> h_err with h_total_meas = 1600; locked falls;
//     relock 2 good frames later.
//  T4 after lock, cut one line's active to 639 clk -> act_err pulse and loss of lock;
//     x peaks at 638 on that line.
//  T5 assert rst at y = 200 for 1 clk -> all outputs 0 the next cycle and state SEARCH;
//     relock as in T2.
//  T6 force the hs and vs assertion edges into the same cycle -> line_start and frame_start
//     both pulse; v_total_meas = 525; no v_err.

Source files
------------

// File: rtl/vga_sync_decoder_pkg.sv
// Shared definitions for the VGA sync decoder.
// Holds the default 640x480 timing (the same numbers vga_timing_gen uses),
// the widths of the recovered coordinate and measurement fields, and the
// lock state encoding.
package vga_sync_decoder_pkg;

    // 640x480 @ 60 Hz defaults
    localparam int VGA_H_TOTAL     = 800;
    localparam int VGA_V_TOTAL     = 525;
    localparam int VGA_H_ACTIVE    = 640;
    localparam int VGA_V_ACTIVE    = 480;
    localparam int VGA_SYNC_POL    = 0;   // 0: hs/vs active-low
    localparam int VGA_LOCK_FRAMES = 2;

    // Field widths
    localparam int X_W    = 10;
    localparam int Y_W    = 10;
    localparam int HCNT_W = 11;
    localparam int VCNT_W = 10;
    localparam int GOOD_W = 8;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } sync_state_t;

endpackage

// File: rtl/vga_sync_decoder_edge_det.sv
// Input register plus edge detector for one sync/enable line.
// Ports:
//   clk, rst - pixel clock, synchronous active-high reset
//   d        - polarity-normalised input (1 = asserted)
//   lvl      - d registered once (first pipeline stage)
//   rise     - lvl went 0 -> 1 this cycle (combinational from the two flops)
//   fall     - lvl went 1 -> 0 this cycle
module vga_sync_decoder_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic lvl,
    output logic rise,
    output logic fall
);

    logic d_p0;
    logic d_p1;

    // stage 1: capture input; d_p1 holds the previous sample for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            d_p0 <= 1'b0;
            d_p1 <= 1'b0;
        end else begin
            d_p0 <= d;
            d_p1 <= d_p0;
        end
    end

    assign lvl  = d_p0;
    assign rise = d_p0 & ~d_p1;
    assign fall = ~d_p0 & d_p1;

endmodule

// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing decoder.
// Recovers pixel coordinates from raw hs/vs/active, measures line and frame
// timing and declares lock once the incoming timing matches the expected mode
// for LOCK_FRAMES consecutive frames.
// Ports:
//   clk, rst        - pixel clock, synchronous active-high reset
//   hs_in, vs_in    - syncs, polarity set by SYNC_POL (0 = active-low)
//   active_in       - display enable, high in the visible region
//   x, y            - recovered column/row, 0 at first active pixel/line
//   pixel_valid     - x/y refer to a visible pixel
//   line_start      - 1-cycle pulse on hs assertion
//   frame_start     - 1-cycle pulse on vs assertion
//   locked          - timing matched for LOCK_FRAMES frames
//   h_err/v_err/act_err - 1-cycle mismatch pulses (never raised in SEARCH)
//   h_total_meas    - last line period, saturating
//   v_total_meas    - last lines per frame, saturating
// All stage-2 outputs lag the inputs by 2 clocks.
module vga_sync_decoder
    import vga_sync_decoder_pkg::*;
#(
    parameter int H_TOTAL     = VGA_H_TOTAL,
    parameter int V_TOTAL     = VGA_V_TOTAL,
    parameter int H_ACTIVE    = VGA_H_ACTIVE,
    parameter int V_ACTIVE    = VGA_V_ACTIVE,
    parameter int SYNC_POL    = VGA_SYNC_POL,
    parameter int LOCK_FRAMES = VGA_LOCK_FRAMES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hs_in,
    input  logic              vs_in,
    input  logic              active_in,
    output logic [X_W-1:0]    x,
    output logic [Y_W-1:0]    y,
    output logic              pixel_valid,
    output logic              line_start,
    output logic              frame_start,
    output logic              locked,
    output logic              h_err,
    output logic              v_err,
    output logic              act_err,
    output logic [HCNT_W-1:0] h_total_meas,
    output logic [VCNT_W-1:0] v_total_meas
);

    localparam logic [HCNT_W-1:0] H_TOTAL_C  = HCNT_W'(H_TOTAL);
    localparam logic [HCNT_W-1:0] H_ACTIVE_C = HCNT_W'(H_ACTIVE);
    localparam logic [VCNT_W-1:0] V_TOTAL_C  = VCNT_W'(V_TOTAL);
    localparam logic [VCNT_W-1:0] V_ACTIVE_C = VCNT_W'(V_ACTIVE);
    localparam logic [GOOD_W-1:0] LOCK_C     = GOOD_W'(LOCK_FRAMES);

    function automatic logic [9:0] sat_inc10(input logic [9:0] v);
        return (v == 10'h3FF) ? v : v + 10'd1;
    endfunction

    function automatic logic [10:0] sat_inc11(input logic [10:0] v);
        return (v == 11'h7FF) ? v : v + 11'd1;
    endfunction

    logic hs_n, vs_n, act_n;
    logic hs_lvl, hs_rise, hs_fall;
    logic vs_lvl, vs_rise, vs_fall;
    logic act_lvl, act_rise, act_fall;
    logic unused_edges;

    sync_state_t       state;
    logic [GOOD_W-1:0] good;
    logic [GOOD_W-1:0] good_next;
    logic              frame_clean;
    logic              err_q;

    logic [HCNT_W-1:0] hcnt;
    logic [VCNT_W-1:0] vcnt;
    logic [VCNT_W-1:0] aline;
    logic              h_primed;

    logic              chk_en;
    logic [VCNT_W-1:0] v_lines;
    logic [VCNT_W-1:0] a_lines;
    logic [HCNT_W-1:0] run_len;

    // stage 0: fold polarity so every line is 1 when asserted
    assign hs_n  = (SYNC_POL != 0) ? hs_in : ~hs_in;
    assign vs_n  = (SYNC_POL != 0) ? vs_in : ~vs_in;
    assign act_n = active_in;

    vga_sync_decoder_edge_det u_hs (
        .clk (clk), .rst (rst), .d (hs_n),
        .lvl (hs_lvl), .rise (hs_rise), .fall (hs_fall)
    );

    vga_sync_decoder_edge_det u_vs (
        .clk (clk), .rst (rst), .d (vs_n),
        .lvl (vs_lvl), .rise (vs_rise), .fall (vs_fall)
    );

    vga_sync_decoder_edge_det u_act (
        .clk (clk), .rst (rst), .d (act_n),
        .lvl (act_lvl), .rise (act_rise), .fall (act_fall)
    );

    assign unused_edges = ^{hs_lvl, hs_fall, vs_lvl, vs_fall};

    // A line_start coinciding with frame_start belongs to the closing frame,
    // so it is folded into the latched count rather than the new one.
    assign v_lines = hs_rise  ? sat_inc10(vcnt)  : vcnt;
    assign a_lines = act_fall ? sat_inc10(aline) : aline;
    // x holds run-1 on the cycle the falling edge is seen
    assign run_len = {1'b0, x} + 11'd1;
    assign chk_en  = (state != ST_SEARCH);

    // stage 2: counters, measurements and all pixel-side outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            x            <= '0;
            y            <= '0;
            pixel_valid  <= 1'b0;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
            h_err        <= 1'b0;
            v_err        <= 1'b0;
            act_err      <= 1'b0;
            h_total_meas <= '0;
            v_total_meas <= '0;
            hcnt         <= '0;
            vcnt         <= '0;
            aline        <= '0;
            h_primed     <= 1'b0;
        end else begin
            pixel_valid <= act_lvl;
            line_start  <= hs_rise;
            frame_start <= vs_rise;
            // the first line after reset is partial, so it is never judged
            h_err       <= hs_rise && h_primed && chk_en && (hcnt != H_TOTAL_C);
            v_err       <= vs_rise && chk_en &&
                           ((v_lines != V_TOTAL_C) || (a_lines != V_ACTIVE_C));
            act_err     <= act_fall && chk_en && (run_len != H_ACTIVE_C);

            if (act_rise) begin
                x <= '0;
            end else if (act_lvl) begin
                x <= sat_inc10(x);
            end

            if (vs_rise) begin
                y <= '0;
            end else if (act_fall) begin
                y <= sat_inc10(y);
            end

            if (hs_rise) begin
                h_total_meas <= hcnt;
                hcnt         <= HCNT_W'(1);
                h_primed     <= 1'b1;
            end else begin
                hcnt <= sat_inc11(hcnt);
            end

            if (vs_rise) begin
                v_total_meas <= v_lines;
                vcnt         <= '0;
                aline        <= '0;
            end else begin
                if (hs_rise) begin
                    vcnt <= sat_inc10(vcnt);
                end
                if (act_fall) begin
                    aline <= sat_inc10(aline);
                end
            end
        end
    end

    assign err_q     = h_err | v_err | act_err;
    assign good_next = good + GOOD_W'(1);

    // stage 3: lock FSM, driven by the registered stage-2 pulses so that
    // a v_err raised at frame_start is charged to the frame it closes
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_SEARCH;
            good        <= '0;
            frame_clean <= 1'b0;
            locked      <= 1'b0;
        end else begin
            case (state)
                ST_SEARCH: begin
                    if (frame_start) begin
                        state       <= ST_ACQUIRE;
                        good        <= '0;
                        frame_clean <= 1'b1;
                    end
                end
                ST_ACQUIRE: begin
                    if (frame_start) begin
                        frame_clean <= 1'b1;
                        if (err_q || !frame_clean) begin
                            good <= '0;
                        end else if (good_next == LOCK_C) begin
                            state  <= ST_LOCKED;
                            locked <= 1'b1;
                            good   <= good_next;
                        end else begin
                            good <= good_next;
                        end
                    end else if (err_q) begin
                        good        <= '0;
                        frame_clean <= 1'b0;
                    end
                end
                ST_LOCKED: begin
                    if (err_q) begin
                        state       <= ST_ACQUIRE;
                        locked      <= 1'b0;
                        good        <= '0;
                        frame_clean <= frame_start;
                    end
                end
                default: begin
                    state       <= ST_SEARCH;
                    locked      <= 1'b0;
                    good        <= '0;
                    frame_clean <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder using a reduced 20x10 timing mode
// (12x6 active, hs asserted at column 14 for 2 clocks, vs for 2 lines).
module tb_vga_sync_decoder;

    localparam int H_T   = 20;
    localparam int H_A   = 12;
    localparam int V_T   = 10;
    localparam int V_A   = 6;
    localparam int LF    = 2;
    localparam int FRAME = H_T * V_T;
    localparam int HS_AT = 14;

    logic        clk = 1'b0;
    logic        rst;
    logic        hs_in, vs_in, active_in;
    logic [9:0]  x, y;
    logic        pixel_valid, line_start, frame_start, locked;
    logic        h_err, v_err, act_err;
    logic [10:0] h_total_meas;
    logic [9:0]  v_total_meas;

    vga_sync_decoder #(
        .H_TOTAL(H_T), .V_TOTAL(V_T), .H_ACTIVE(H_A), .V_ACTIVE(V_A),
        .SYNC_POL(0), .LOCK_FRAMES(LF)
    ) dut (
        .clk(clk), .rst(rst), .hs_in(hs_in), .vs_in(vs_in), .active_in(active_in),
        .x(x), .y(y), .pixel_valid(pixel_valid), .line_start(line_start),
        .frame_start(frame_start), .locked(locked), .h_err(h_err), .v_err(v_err),
        .act_err(act_err), .h_total_meas(h_total_meas), .v_total_meas(v_total_meas)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // generator controls
    int pos = 0, vs_start = 140, skip_line = -1, short_line = -1;
    int q1 = -1, q2 = -1;
    int cyc = 0;
    bit strict = 1'b0;

    // observation bookkeeping
    int fs_cnt, fs_at[16], lock_rise, lock_fall, prev_locked;
    int herr_cnt, verr_cnt, aerr_cnt, herr_meas, verr_meas, herr_cyc, aerr_cyc;
    int both_cnt, xpeak;

    task automatic clear_stats();
        fs_cnt = 0;
        for (int i = 0; i < 16; i++) fs_at[i] = -1000;
        lock_rise = -1; lock_fall = -1; prev_locked = int'(locked);
        herr_cnt = 0; verr_cnt = 0; aerr_cnt = 0;
        herr_meas = -1; verr_meas = -1; herr_cyc = -1; aerr_cyc = -1;
        both_cnt = 0; xpeak = 0;
    endtask

    function automatic int lock_near(input int k);
        return (fs_cnt > k && lock_rise >= fs_at[k] && lock_rise <= fs_at[k] + 1) ? 1 : 0;
    endfunction

    task automatic drive(input int p);
        int hc, vc;
        if (p < 0) begin
            hs_in     = 1'($urandom_range(0, 1));
            vs_in     = 1'($urandom_range(0, 1));
            active_in = 1'($urandom_range(0, 1));
        end else begin
            hc = p % H_T;
            vc = p / H_T;
            active_in = (hc < H_A) && (vc < V_A) && !(vc == short_line && hc == H_A - 1);
            hs_in     = !((hc == HS_AT || hc == HS_AT + 1) && vc != skip_line);
            vs_in     = !(p >= vs_start && p < vs_start + 2 * H_T);
        end
        q2 = q1;
        q1 = p;
    endtask

    // outputs now reflect the position driven two drives ago (q2)
    task automatic sample();
        int hc, vc;
        bit act_e;
        if (frame_start) begin
            if (fs_cnt < 16) fs_at[fs_cnt] = cyc;
            fs_cnt++;
        end
        if (locked && prev_locked == 0 && lock_rise < 0) lock_rise = cyc;
        if (!locked && prev_locked == 1 && lock_fall < 0) lock_fall = cyc;
        prev_locked = int'(locked);
        if (h_err) begin herr_cnt++; herr_meas = int'(h_total_meas); if (herr_cyc < 0) herr_cyc = cyc; end
        if (v_err) begin verr_cnt++; verr_meas = int'(v_total_meas); end
        if (act_err) begin aerr_cnt++; if (aerr_cyc < 0) aerr_cyc = cyc; end
        if (line_start && frame_start) both_cnt++;
        if (pixel_valid && q2 >= 0 && (q2 / H_T) == short_line && int'(x) > xpeak) xpeak = int'(x);
        if (strict && q2 >= 0) begin
            hc = q2 % H_T;
            vc = q2 / H_T;
            act_e = (hc < H_A) && (vc < V_A);
            check("pix_valid", int'(pixel_valid), int'(act_e));
            if (act_e) begin
                check("x", int'(x), hc);
                check("y", int'(y), vc);
            end
            check("line_start", int'(line_start), int'(hc == HS_AT));
            check("frame_start", int'(frame_start), int'(q2 == vs_start));
            check("err_flags", int'({h_err, v_err, act_err}), 0);
            check("locked_hold", int'(locked), 1);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        sample();
    endtask

    task automatic run(input int n);
        repeat (n) begin
            drive(pos);
            pos = (pos + 1) % FRAME;
            tick();
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_xy"},    int'({x, y}), 0);
        check({tag, "_flags"}, int'({pixel_valid, line_start, frame_start, locked,
                                     h_err, v_err, act_err}), 0);
        check({tag, "_meas"},  int'({h_total_meas, v_total_meas}), 0);
    endtask

    initial begin
        rst = 1'b1;
        clear_stats();

        // T1: reset with random syncs, then a clean first frame
        repeat (3) begin drive(-1); tick(); end
        check_all_zero("t1_rst");
        rst = 1'b0;
        pos = 0;
        clear_stats();
        run(FRAME);
        check("t1_first_frame_err", herr_cnt + verr_cnt + aerr_cnt, 0);

        // T2: lock at third frame_start, measurements, one full frame tracked
        run(2 * FRAME + 10);
        check("t2_lock_at_fs3", lock_near(2), 1);
        check("t2_h_meas", int'(h_total_meas), H_T);
        check("t2_v_meas", int'(v_total_meas), V_T);
        check("t2_no_err", herr_cnt + verr_cnt + aerr_cnt, 0);
        strict = 1'b1;
        run(FRAME);
        strict = 1'b0;

        // T3: one missing hs pulse on line 2
        run((FRAME - pos) % FRAME);
        clear_stats();
        skip_line = 2;
        run(FRAME);
        skip_line = -1;
        run(3 * FRAME);
        check("t3_herr_cnt", herr_cnt, 1);
        check("t3_h_meas", herr_meas, 2 * H_T);
        check("t3_verr_cnt", verr_cnt, 1);
        check("t3_v_meas", verr_meas, V_T - 1);
        check("t3_lock_fall", int'(herr_cyc >= 0 && lock_fall >= herr_cyc && lock_fall <= herr_cyc + 1), 1);
        check("t3_relock", lock_near(2), 1);

        // T4: line 3 active shortened by one clock
        clear_stats();
        short_line = 3;
        run(FRAME);
        short_line = -1;
        run(3 * FRAME);
        check("t4_aerr_cnt", aerr_cnt, 1);
        check("t4_x_peak", xpeak, H_A - 2);
        check("t4_hv_err", herr_cnt + verr_cnt, 0);
        check("t4_lock_fall", int'(aerr_cyc >= 0 && lock_fall >= aerr_cyc && lock_fall <= aerr_cyc + 1), 1);
        check("t4_relock", lock_near(2), 1);

        // T5: single-cycle reset in the middle of active line 3
        run((3 * H_T + 5 - pos + FRAME) % FRAME);
        rst = 1'b1;
        drive(pos);
        pos = (pos + 1) % FRAME;
        tick();
        check_all_zero("t5_rst");
        rst = 1'b0;
        clear_stats();
        run(3 * FRAME);
        check("t5_relock", lock_near(2), 1);
        check("t5_no_err", herr_cnt + verr_cnt + aerr_cnt, 0);

        // T6: vs asserted in the same cycle as hs
        rst = 1'b1;
        vs_start = 7 * H_T + HS_AT;
        repeat (2) begin drive(-1); tick(); end
        check("t6_rst_lock", int'(locked), 0);
        rst = 1'b0;
        pos = 0;
        clear_stats();
        run(4 * FRAME);
        check("t6_fs_cnt", fs_cnt, 4);
        check("t6_both_pulse", both_cnt, 4);
        check("t6_v_meas", int'(v_total_meas), V_T);
        check("t6_no_verr", verr_cnt, 0);
        check("t6_other_err", herr_cnt + aerr_cnt, 0);
        check("t6_lock", lock_near(2), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
